// File: rtl/dt_pkg.sv
// Shared definitions for the ridge extractor: image geometry, FSM states,
// neighbour offset tables and small mask helpers.
// Build option: DT_RIDGE_DIAG_EN adds the four diagonal neighbours.
package dt_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int WORD_BITS = 16;

`ifdef DT_RIDGE_DIAG_EN
  localparam int NB_N  = 8;
  localparam int NB_IW = 3;
`else
  localparam int NB_N  = 4;
  localparam int NB_IW = 2;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_C   = 3'd1,
    EV_C   = 3'd2,
    RD_NB  = 3'd3,
    CMP_NB = 3'd4,
    ACC    = 3'd5,
    WR     = 3'd6,
    FIN    = 3'd7
  } state_t;

  // Neighbour order: N, W, E, S, NW, NE, SW, SE
  localparam logic signed [1:0] NB_DX [8] = '{2'sd0, -2'sd1, 2'sd1, 2'sd0,
                                              -2'sd1, 2'sd1, -2'sd1, 2'sd1};
  localparam logic signed [1:0] NB_DY [8] = '{-2'sd1, 2'sd0, 2'sd0, 2'sd1,
                                              -2'sd1, -2'sd1, 2'sd1, 2'sd1};

  // Bits set for every neighbour index strictly after idx
  function automatic logic [NB_N-1:0] above_mask(input logic [NB_IW-1:0] idx);
    logic [NB_N-1:0] m;
    m = '0;
    for (int k = 0; k < NB_N; k++) m[k] = (k > int'(idx));
    return m;
  endfunction

  // Lowest set bit of a neighbour mask (0 when empty)
  function automatic logic [NB_IW-1:0] first_idx(input logic [NB_N-1:0] m);
    logic [NB_IW-1:0] r;
    r = '0;
    for (int k = NB_N - 1; k >= 0; k--) if (m[k]) r = NB_IW'(k);
    return r;
  endfunction

endpackage

// File: rtl/dt_nb_addr_gen.sv
// Maps a pixel and neighbour index to the neighbour's map address and an
// in-image flag. The 8-bit sums expose under/overflow in bit 7, so an edge
// neighbour is flagged instead of wrapping into the next row.
module dt_nb_addr_gen
  import dt_pkg::*;
(
  input  logic [6:0]       x,
  input  logic [6:0]       y,
  input  logic [NB_IW-1:0] idx,
  output logic [13:0]      addr,
  output logic             in_img
);

  logic signed [1:0] dx;
  logic signed [1:0] dy;
  logic [7:0]        nx;
  logic [7:0]        ny;

  assign dx     = NB_DX[3'(idx)];
  assign dy     = NB_DY[3'(idx)];
  assign nx     = {1'b0, x} + {{6{dx[1]}}, dx};
  assign ny     = {1'b0, y} + {{6{dy[1]}}, dy};
  assign in_img = ~nx[7] & ~ny[7];
  assign addr   = {ny[6:0], nx[6:0]};

endmodule

// File: rtl/dt_ridge_extract.sv
// Ridge extractor: raster-scans a 128x128 distance map and packs one ridge
// bit per pixel into 16-bit words (bit 15 = leftmost pixel).
// Build option: DT_RIDGE_DIAG_EN compares the 8-neighbourhood.
// Memory handshake: res_rd/res_addr are registered; res_di is valid in the
// cycle after res_rd is high. skel_wr is a one-cycle strobe qualifying
// skel_addr/skel_do. state_dbg mirrors the FSM state for observation.
module dt_ridge_extract
  import dt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        skel_wr,
  output logic [9:0]  skel_addr,
  output logic [15:0] skel_do,
  output logic        done,
  output logic [2:0]  state_dbg
);

  state_t                 state;
  logic [13:0]            pix;        // {y, x}
  logic [NB_IW-1:0]       nb_idx;     // last neighbour issued
  logic [7:0]             center;
  logic                   ridge_bit;
  logic                   last_pix;
  logic [WORD_BITS-1:0]   word;

  logic [13:0]            nb_addr [NB_N];
  logic [NB_N-1:0]        nb_in;
  logic [NB_N-1:0]        cand;
  logic [NB_IW-1:0]       nb_sel;
  logic [WORD_BITS-1:0]   word_shift;

  for (genvar g = 0; g < NB_N; g++) begin : g_nb
    dt_nb_addr_gen u_addr (
      .x      (pix[6:0]),
      .y      (pix[13:7]),
      .idx    (NB_IW'(g)),
      .addr   (nb_addr[g]),
      .in_img (nb_in[g])
    );
  end

  // Remaining in-image neighbours: all of them on the first pick, otherwise
  // those after the last issued one. Choosing the next read one state early
  // keeps a foreground pixel at 3 + 2 cycles per neighbour read.
  assign cand       = (state == EV_C) ? nb_in : (nb_in & above_mask(nb_idx));
  assign nb_sel     = first_idx(cand);
  assign word_shift = {word[WORD_BITS-2:0], ridge_bit};
  assign state_dbg  = state;

  // Scan FSM with registered memory strobes and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pix       <= '0;
      nb_idx    <= '0;
      center    <= '0;
      ridge_bit <= 1'b0;
      last_pix  <= 1'b0;
      word      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_rd    <= 1'b0;
      res_addr  <= '0;
      skel_wr   <= 1'b0;
      skel_addr <= '0;
      skel_do   <= '0;
    end else begin
      res_rd  <= 1'b0;
      skel_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pix      <= '0;
            nb_idx   <= '0;
            word     <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            res_rd   <= 1'b1;
            res_addr <= '0;
            state    <= RD_C;
          end
        end
        RD_C: state <= EV_C;
        EV_C: begin
          center <= res_di;
          if (res_di == 8'd0) begin
            ridge_bit <= 1'b0;
            state     <= ACC;
          end else if (cand == '0) begin
            ridge_bit <= 1'b1;
            state     <= ACC;
          end else begin
            nb_idx   <= nb_sel;
            res_rd   <= 1'b1;
            res_addr <= nb_addr[nb_sel];
            state    <= RD_NB;
          end
        end
        // The read for this neighbour is already on the bus; the
        // "none remain" decision was taken when it was selected.
        RD_NB: state <= CMP_NB;
        CMP_NB: begin
          if (res_di > center) begin
            ridge_bit <= 1'b0;
            state     <= ACC;
          end else if (cand == '0) begin
            ridge_bit <= 1'b1;
            state     <= ACC;
          end else begin
            nb_idx   <= nb_sel;
            res_rd   <= 1'b1;
            res_addr <= nb_addr[nb_sel];
            state    <= RD_NB;
          end
        end
        ACC: begin
          word <= word_shift;
          pix  <= pix + 14'd1;
          if (pix[3:0] == 4'hF) begin
            skel_wr   <= 1'b1;
            skel_do   <= word_shift;
            skel_addr <= {pix[13:7], pix[6:4]};
            last_pix  <= (pix == 14'h3FFF);
            state     <= WR;
          end else begin
            res_rd   <= 1'b1;
            res_addr <= pix + 14'd1;
            state    <= RD_C;
          end
        end
        WR: begin
          if (last_pix) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            res_rd   <= 1'b1;
            res_addr <= pix;
            state    <= RD_C;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
